// File: rtl/mandel_view_ctrl.sv
// mandel_view_ctrl: AXI-Lite view register block for the Mandelbrot pipeline.
// Software writes shadow centre/zoom/step values; they become the active outputs
// only at a frame boundary detected from the stream-domain frame_start_tgl.
// Optional auto-zoom nudges the active zoom by the signed step once per frame.
// cfg_update_tgl flips whenever the active outputs change so the consumer can resync.
module mandel_view_ctrl #(
    parameter int WORD_LENGTH         = 64,
    parameter int FRAC                = 60,
    parameter int AXI_LITE_ADDR_WIDTH = 8
) (
    input  logic                           s_axi_lite_aclk,
    input  logic                           periph_resetn,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
    input  logic                           s_axi_lite_awvalid,
    output logic                           s_axi_lite_awready,
    input  logic [31:0]                    s_axi_lite_wdata,
    input  logic                           s_axi_lite_wvalid,
    output logic                           s_axi_lite_wready,
    output logic [1:0]                     s_axi_lite_bresp,
    output logic                           s_axi_lite_bvalid,
    input  logic                           s_axi_lite_bready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
    input  logic                           s_axi_lite_arvalid,
    output logic                           s_axi_lite_arready,
    output logic [31:0]                    s_axi_lite_rdata,
    output logic [1:0]                     s_axi_lite_rresp,
    output logic                           s_axi_lite_rvalid,
    input  logic                           s_axi_lite_rready,
    input  logic                           frame_start_tgl,
    output logic [WORD_LENGTH-1:0]         re_center_o,
    output logic [WORD_LENGTH-1:0]         im_center_o,
    output logic [31:0]                    zoom_o,
    output logic                           cfg_update_tgl
);

    localparam logic [WORD_LENGTH-1:0] THREE_C   = WORD_LENGTH'(3);
    // -0.75 in signed Q(WORD_LENGTH-FRAC).FRAC
    localparam logic [WORD_LENGTH-1:0] RE_RESET  = ~(THREE_C << (FRAC - 2)) + WORD_LENGTH'(1);
    localparam logic [31:0]            ZOOM_RESET = 32'd1024;
    localparam logic [1:0]             RESP_OKAY  = 2'b00;
    localparam logic [1:0]             RESP_SLV   = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WRITE = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

    wstate_t                wstate_q, wstate_d;
    rstate_t                rstate_q, rstate_d;
    logic                   aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic                   aw_bad_q, aw_bad_d, ar_bad_q, ar_bad_d;
    logic [2:0]             aw_word_q, aw_word_d, ar_word_q, ar_word_d;
    logic [31:0]            wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
    logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [WORD_LENGTH-1:0] sh_re_q, sh_re_d, sh_im_q, sh_im_d;
    logic [WORD_LENGTH-1:0] act_re_q, act_re_d, act_im_q, act_im_d;
    logic [31:0]            sh_zoom_q, sh_zoom_d, sh_step_q, sh_step_d;
    logic [31:0]            act_zoom_q, act_zoom_d;
    logic                   auto_zoom_q, auto_zoom_d, pending_q, pending_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   tgl_q, tgl_d;
    logic                   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic                   boundary_s, commit_s;
    logic [31:0]            next_zoom_s;
    logic                   unused_s;

    // Saturating zoom update: result clamped to [1, 2^32-1].
    function automatic logic [31:0] sat_zoom(input logic [31:0] zoom, input logic [31:0] step);
        logic signed [33:0] sum;
        sum = $signed({2'b00, zoom}) + $signed({{2{step[31]}}, step});
        if (sum < 34'sd1) begin
            sat_zoom = 32'd1;
        end else if (sum > 34'sh0_FFFF_FFFF) begin
            sat_zoom = 32'hFFFF_FFFF;
        end else begin
            sat_zoom = sum[31:0];
        end
    endfunction

    assign unused_s           = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};
    assign s_axi_lite_awready = (wstate_q == W_IDLE) && !aw_got_q;
    assign s_axi_lite_wready  = (wstate_q == W_IDLE) && !w_got_q;
    assign s_axi_lite_arready = (rstate_q == R_IDLE);
    assign s_axi_lite_bvalid  = bvalid_q;
    assign s_axi_lite_bresp   = bresp_q;
    assign s_axi_lite_rvalid  = rvalid_q;
    assign s_axi_lite_rresp   = rresp_q;
    assign s_axi_lite_rdata   = rdata_q;
    assign re_center_o        = act_re_q;
    assign im_center_o        = act_im_q;
    assign zoom_o             = act_zoom_q;
    assign cfg_update_tgl     = tgl_q;

    // Write channel FSM: collect AW and W in any order, apply to shadow regs, respond.
    always_comb begin
        wstate_d    = wstate_q;
        aw_got_d    = aw_got_q;
        w_got_d     = w_got_q;
        aw_bad_d    = aw_bad_q;
        aw_word_d   = aw_word_q;
        wdata_d     = wdata_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        sh_re_d     = sh_re_q;
        sh_im_d     = sh_im_q;
        sh_zoom_d   = sh_zoom_q;
        sh_step_d   = sh_step_q;
        auto_zoom_d = auto_zoom_q;
        commit_s    = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (s_axi_lite_awvalid && !aw_got_q) begin
                    aw_got_d  = 1'b1;
                    aw_bad_d  = |s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:5];
                    aw_word_d = s_axi_lite_awaddr[4:2];
                end else begin
                    aw_got_d = aw_got_q;
                end
                if (s_axi_lite_wvalid && !w_got_q) begin
                    w_got_d = 1'b1;
                    wdata_d = s_axi_lite_wdata;
                end else begin
                    w_got_d = w_got_q;
                end
                if (aw_got_d && w_got_d) begin
                    wstate_d = W_WRITE;
                end else begin
                    wstate_d = W_IDLE;
                end
            end
            W_WRITE: begin
                wstate_d = W_RESP;
                bvalid_d = 1'b1;
                if (aw_bad_q) begin
                    bresp_d = RESP_SLV;
                end else begin
                    bresp_d = RESP_OKAY;
                    case (aw_word_q)
                        3'd0: begin
                            auto_zoom_d = wdata_q[1];
                            commit_s    = wdata_q[0];
                        end
                        3'd2:    sh_re_d[31:0]             = wdata_q;
                        3'd3:    sh_re_d[WORD_LENGTH-1:32] = wdata_q[WORD_LENGTH-33:0];
                        3'd4:    sh_im_d[31:0]             = wdata_q;
                        3'd5:    sh_im_d[WORD_LENGTH-1:32] = wdata_q[WORD_LENGTH-33:0];
                        3'd6:    sh_zoom_d                 = wdata_q;
                        3'd7:    sh_step_d                 = wdata_q;
                        default: sh_step_d                 = sh_step_q;
                    endcase
                end
            end
            W_RESP: begin
                if (s_axi_lite_bready) begin
                    bvalid_d = 1'b0;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    wstate_d = W_IDLE;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                wstate_d = W_IDLE;
                bvalid_d = 1'b0;
                aw_got_d = 1'b0;
                w_got_d  = 1'b0;
            end
        endcase
    end

    // Read channel FSM: capture address, fetch register one cycle later, hold until rready.
    always_comb begin
        rstate_d  = rstate_q;
        ar_bad_d  = ar_bad_q;
        ar_word_d = ar_word_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rvalid_d  = rvalid_q;
        case (rstate_q)
            R_IDLE: begin
                if (s_axi_lite_arvalid) begin
                    ar_bad_d  = |s_axi_lite_araddr[AXI_LITE_ADDR_WIDTH-1:5];
                    ar_word_d = s_axi_lite_araddr[4:2];
                    rstate_d  = R_FETCH;
                end else begin
                    rstate_d = R_IDLE;
                end
            end
            R_FETCH: begin
                rvalid_d = 1'b1;
                rstate_d = R_DATA;
                if (ar_bad_q) begin
                    rdata_d = 32'd0;
                    rresp_d = RESP_SLV;
                end else begin
                    rresp_d = RESP_OKAY;
                    case (ar_word_q)
                        3'd0:    rdata_d = {30'd0, auto_zoom_q, 1'b0};
                        3'd1:    rdata_d = {frame_cnt_q, 15'd0, pending_q};
                        3'd2:    rdata_d = sh_re_q[31:0];
                        3'd3:    rdata_d = 32'(sh_re_q[WORD_LENGTH-1:32]);
                        3'd4:    rdata_d = sh_im_q[31:0];
                        3'd5:    rdata_d = 32'(sh_im_q[WORD_LENGTH-1:32]);
                        3'd6:    rdata_d = sh_zoom_q;
                        3'd7:    rdata_d = sh_step_q;
                        default: rdata_d = 32'd0;
                    endcase
                end
            end
            R_DATA: begin
                if (s_axi_lite_rready) begin
                    rvalid_d = 1'b0;
                    rstate_d = R_IDLE;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                rstate_d = R_IDLE;
                rvalid_d = 1'b0;
            end
        endcase
    end

    // Frame boundary detection and commit / auto-zoom of the active view.
    always_comb begin
        sync1_d     = frame_start_tgl;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        boundary_s  = sync2_q ^ prev_q;
        frame_cnt_d = frame_cnt_q;
        pending_d   = pending_q;
        act_re_d    = act_re_q;
        act_im_d    = act_im_q;
        act_zoom_d  = act_zoom_q;
        tgl_d       = tgl_q;
        next_zoom_s = sat_zoom(act_zoom_q, sh_step_q);
        if (boundary_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (pending_q) begin
                act_re_d   = sh_re_q;
                act_im_d   = sh_im_q;
                act_zoom_d = sh_zoom_q;
                pending_d  = 1'b0;
                tgl_d      = ~tgl_q;
            end else if (auto_zoom_q) begin
                act_zoom_d = next_zoom_s;
                if (next_zoom_s != act_zoom_q) begin
                    tgl_d = ~tgl_q;
                end else begin
                    tgl_d = tgl_q;
                end
            end else begin
                act_zoom_d = act_zoom_q;
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        // A commit seen in the boundary cycle lands after the old pending was sampled.
        if (commit_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            wstate_q    <= W_IDLE;
            rstate_q    <= R_IDLE;
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            aw_bad_q    <= 1'b0;
            ar_bad_q    <= 1'b0;
            aw_word_q   <= 3'd0;
            ar_word_q   <= 3'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            bresp_q     <= 2'b00;
            rresp_q     <= 2'b00;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            sh_re_q     <= RE_RESET;
            sh_im_q     <= {WORD_LENGTH{1'b0}};
            sh_zoom_q   <= ZOOM_RESET;
            sh_step_q   <= 32'd0;
            act_re_q    <= RE_RESET;
            act_im_q    <= {WORD_LENGTH{1'b0}};
            act_zoom_q  <= ZOOM_RESET;
            auto_zoom_q <= 1'b0;
            pending_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
            tgl_q       <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
        end else begin
            wstate_q    <= wstate_d;
            rstate_q    <= rstate_d;
            aw_got_q    <= aw_got_d;
            w_got_q     <= w_got_d;
            aw_bad_q    <= aw_bad_d;
            ar_bad_q    <= ar_bad_d;
            aw_word_q   <= aw_word_d;
            ar_word_q   <= ar_word_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            sh_re_q     <= sh_re_d;
            sh_im_q     <= sh_im_d;
            sh_zoom_q   <= sh_zoom_d;
            sh_step_q   <= sh_step_d;
            act_re_q    <= act_re_d;
            act_im_q    <= act_im_d;
            act_zoom_q  <= act_zoom_d;
            auto_zoom_q <= auto_zoom_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            tgl_q       <= tgl_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
        end
    end

endmodule

// File: tb/tb_mandel_view_ctrl.sv
// Bench for mandel_view_ctrl: directed scenarios plus randomized register/frame
// traffic, checked by a scoreboard fed from a behavioural view model.
module tb_mandel_view_ctrl;

    localparam logic [63:0] RE_RST = 64'hF400_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  awaddr = 8'd0, araddr = 8'd0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        fst = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, tgl;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, zoom;
    logic [63:0] re, im;

    mandel_view_ctrl #(.WORD_LENGTH(64), .FRAC(60), .AXI_LITE_ADDR_WIDTH(8)) dut (
        .s_axi_lite_aclk(clk), .periph_resetn(rstn),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
        .s_axi_lite_rready(rready), .frame_start_tgl(fst),
        .re_center_o(re), .im_center_o(im), .zoom_o(zoom), .cfg_update_tgl(tgl)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [63:0] re;
        logic [63:0] im;
        logic [31:0] zoom;
    } cfg_t;

    cfg_t        exp_cfg[$];
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];

    // behavioural view model
    logic [63:0] m_sh_re, m_sh_im, m_act_re, m_act_im;
    logic [31:0] m_sh_zoom, m_sh_step, m_act_zoom;
    logic        m_auto, m_pending, m_tgl;
    logic [15:0] m_frame;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s got=timeout want=response t=%0t", name, $time);
    endtask

    task automatic model_reset();
        m_sh_re = RE_RST; m_act_re = RE_RST;
        m_sh_im = 64'd0;  m_act_im = 64'd0;
        m_sh_zoom = 32'd1024; m_act_zoom = 32'd1024;
        m_sh_step = 32'd0;
        m_auto = 1'b0; m_pending = 1'b0; m_tgl = 1'b0; m_frame = 16'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] w);
        case (w)
            3'd0:    return {30'd0, m_auto, 1'b0};
            3'd1:    return {m_frame, 15'd0, m_pending};
            3'd2:    return m_sh_re[31:0];
            3'd3:    return m_sh_re[63:32];
            3'd4:    return m_sh_im[31:0];
            3'd5:    return m_sh_im[63:32];
            3'd6:    return m_sh_zoom;
            default: return m_sh_step;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [31:0] d);
        if (addr[7:5] == 3'd0) begin
            case (addr[4:2])
                3'd0: begin m_auto = d[1]; if (d[0]) m_pending = 1'b1; end
                3'd2: m_sh_re[31:0]  = d;
                3'd3: m_sh_re[63:32] = d;
                3'd4: m_sh_im[31:0]  = d;
                3'd5: m_sh_im[63:32] = d;
                3'd6: m_sh_zoom = d;
                3'd7: m_sh_step = d;
                default: ;
            endcase
        end
    endtask

    // scoreboard monitor: compares whenever the DUT presents a response or a view update
    logic last_tgl = 1'b0;
    always @(negedge clk) begin
        cfg_t e;
        logic [33:0] er;
        if (!rstn) begin
            last_tgl = 1'b0;
        end else begin
            if (tgl !== last_tgl) begin
                last_tgl = tgl;
                if (exp_cfg.size() == 0) begin
                    check("unexpected_cfg_update", {63'd0, tgl}, {63'd0, ~tgl});
                end else begin
                    e = exp_cfg.pop_front();
                    check("cfg_re", re, e.re);
                    check("cfg_im", im, e.im);
                    check("cfg_zoom", {32'd0, zoom}, {32'd0, e.zoom});
                end
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) check("unexpected_bresp", {62'd0, bresp}, 64'hFF);
                else check("bresp", {62'd0, bresp}, {62'd0, exp_b.pop_front()});
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    check("unexpected_rdata", {30'd0, rresp, rdata}, 64'hFFFF_FFFF_FFFF);
                end else begin
                    er = exp_r.pop_front();
                    check("rresp", {62'd0, rresp}, {62'd0, er[33:32]});
                    check("rdata", {32'd0, rdata}, {32'd0, er[31:0]});
                end
            end
        end
    end

    // w_lead > 0: W shown that many cycles before AW; < 0: AW first
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] d,
                             input int w_lead, input int bdelay);
        int cyc, aw_start, w_start, b_seen_cyc;
        bit aw_done, w_done, b_done, b_seen, held_ok;
        exp_b.push_back((addr[7:5] != 3'd0) ? 2'b10 : 2'b00);
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 0; w_done = 0; b_done = 0; b_seen = 0; held_ok = 1; b_seen_cyc = 0;
        @(posedge clk); #1;
        awaddr = addr; wdata = d;
        cyc = 0;
        while (!b_done && cyc < 100) begin
            awvalid = !aw_done && (cyc >= aw_start);
            wvalid  = !w_done && (cyc >= w_start);
            bready  = b_seen && ((cyc - b_seen_cyc) >= bdelay);
            @(negedge clk);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            if (bvalid && !b_seen) begin b_seen = 1; b_seen_cyc = cyc; end
            else if (b_seen && !bvalid) held_ok = 0;
            if (bvalid && bready) b_done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        if (!b_done) begin
            fail_now("write_response");
            void'(exp_b.pop_back());
        end else begin
            model_write(addr, d);
            if (bdelay > 0) check("bvalid_held", {63'd0, held_ok}, 64'd1);
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, input int rdelay);
        int cyc;
        bit got_ar;
        exp_r.push_back((addr[7:5] != 3'd0) ? {2'b10, 32'd0} : {2'b00, model_read(addr[4:2])});
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        cyc = 0; got_ar = 0;
        while (!got_ar && cyc < 50) begin
            @(negedge clk);
            if (arready) got_ar = 1;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        if (!rvalid) begin
            fail_now("read_response");
            void'(exp_r.pop_back());
        end else begin
            repeat (rdelay) begin @(posedge clk); #1; end
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic frame_tick();
        logic old_tgl;
        longint s;
        int st;
        logic [31:0] nz;
        old_tgl = m_tgl;
        m_frame = m_frame + 16'd1;
        if (m_pending) begin
            m_act_re = m_sh_re; m_act_im = m_sh_im; m_act_zoom = m_sh_zoom;
            m_pending = 1'b0;
            m_tgl = ~m_tgl;
            exp_cfg.push_back({m_act_re, m_act_im, m_act_zoom});
        end else if (m_auto) begin
            st = m_sh_step;
            s = longint'(m_act_zoom) + longint'(st);
            if (s < 1) nz = 32'd1;
            else if (s > 64'sh0_FFFF_FFFF) nz = 32'hFFFF_FFFF;
            else nz = s[31:0];
            if (nz != m_act_zoom) begin
                m_act_zoom = nz;
                m_tgl = ~m_tgl;
                exp_cfg.push_back({m_act_re, m_act_im, m_act_zoom});
            end
        end
        @(posedge clk); #1;
        fst = ~fst;
        @(posedge clk);
        @(posedge clk); #1;
        check("tgl_before_k2", {63'd0, tgl}, {63'd0, old_tgl});
        @(posedge clk); #1;
        check("tgl_at_k2", {63'd0, tgl}, {63'd0, m_tgl});
        check("zoom_at_k2", {32'd0, zoom}, {32'd0, m_act_zoom});
        check("re_at_k2", re, m_act_re);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_re"}, re, RE_RST);
        check({tag, "_im"}, im, 64'd0);
        check({tag, "_zoom"}, {32'd0, zoom}, 64'd1024);
        check({tag, "_tgl"}, {63'd0, tgl}, 64'd0);
        check({tag, "_rvalid"}, {63'd0, rvalid}, 64'd0);
        check({tag, "_bvalid"}, {63'd0, bvalid}, 64'd0);
        check({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
        check({tag, "_ready"}, {61'd0, awready, wready, arready}, 64'd7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        logic [31:0] d;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset");
        axi_read(8'h04, 0);

        // commit a new real centre
        axi_write(8'h08, 32'h0000_0000, 0, 0);
        axi_write(8'h0C, 32'hF000_0000, -1, 1);
        axi_write(8'h00, 32'h1, 1, 0);
        axi_read(8'h04, 2);
        frame_tick();
        check("re_committed", re, 64'hF000_0000_0000_0000);
        axi_read(8'h04, 0);

        // auto-zoom by +100 for three frames
        axi_write(8'h1C, 32'd100, 0, 0);
        axi_write(8'h00, 32'h2, 0, 0);
        repeat (3) frame_tick();
        check("zoom_after_3", {32'd0, zoom}, 64'd1324);

        // clamp at 1
        axi_write(8'h18, 32'd5, 0, 0);
        axi_write(8'h00, 32'h1, 0, 0);
        frame_tick();
        axi_write(8'h1C, 32'hFFFF_FFF6, 0, 0);
        axi_write(8'h00, 32'h2, 0, 0);
        frame_tick();
        frame_tick();
        check("zoom_clamped", {32'd0, zoom}, 64'd1);

        // W before AW, slow bready, STATUS write ignored, bad addresses
        axi_write(8'h1C, 32'h0000_0007, 3, 5);
        axi_read(8'h1C, 0);
        axi_write(8'h04, 32'hFFFF_FFFF, 0, 0);
        axi_write(8'h40, 32'hDEAD_BEEF, 0, 2);
        axi_read(8'h40, 1);
        axi_read(8'h04, 0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: begin
                    d = ($urandom_range(0, 1) == 0) ? $urandom : (32'($urandom_range(0, 4000)) - 32'd2000);
                    axi_write({3'd0, 3'($urandom_range(2, 7)), 2'b00}, d,
                              int'($urandom_range(0, 6)) - 3, $urandom_range(0, 3));
                end
                3: axi_write(8'h00, {30'd0, 1'($urandom_range(0, 1)), 1'b1}, 0, $urandom_range(0, 2));
                4: axi_write(8'h00, {30'd0, 1'($urandom_range(0, 1)), 1'b0}, 0, 0);
                5, 6: frame_tick();
                7, 8: axi_read({3'd0, 3'($urandom_range(1, 7)), 2'b00}, $urandom_range(0, 3));
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        axi_write({3'($urandom_range(1, 7)), 5'($urandom)}, $urandom, 0, 1);
                    else
                        axi_read({3'($urandom_range(1, 7)), 5'($urandom)}, 1);
                end
            endcase
        end
        frame_tick();
        if (fst) frame_tick();

        // reset in the middle of a read with a commit pending
        axi_write(8'h18, 32'd777, 0, 0);
        axi_write(8'h00, 32'h1, 0, 0);
        axi_read(8'h04, 0);
        @(posedge clk); #1;
        araddr = 8'h04; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #1;
        check("rvalid_before_reset", {63'd0, rvalid}, 64'd1);
        rstn = 1'b0;
        exp_r.delete(); exp_b.delete(); exp_cfg.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        rstn = 1'b1;
        axi_read(8'h04, 0);
        frame_tick();
        check_reset_outputs("after_frame");
        axi_read(8'h04, 0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_cfg_empty", 64'(exp_cfg.size()), 64'd0);
        check("scoreboard_b_empty", 64'(exp_b.size()), 64'd0);
        check("scoreboard_r_empty", 64'(exp_r.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
